// File: rtl/block_demux_1_to_2_hold_sync_high_reset_pkg.sv
// Shared FFT constants and small types for the block demultiplexer.
// The FFT size and the default block length are defined here so every user agrees on them.
package block_demux_1_to_2_hold_sync_high_reset_pkg;

  localparam int FFT_SIZE          = 64;
  localparam int DEFAULT_BLOCK_LEN = FFT_SIZE / 2;

  localparam logic PATH_0 = 1'b0;
  localparam logic PATH_1 = 1'b1;

  typedef struct packed {
    logic valid0;
    logic valid1;
    logic blk_done;
  } out_flags_t;

endpackage

// File: rtl/block_demux_1_to_2_hold_sync_high_reset_dff.sv
// Data register with synchronous active-high reset and a hold (load-disable) input.
// Reset wins over hold.
module dff_hold_sync_high_reset #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = hold ? q_q : d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/block_demux_1_to_2_hold_sync_high_reset.sv
// 1-to-2 block demultiplexer: consecutive blocks of BLOCK_LEN accepted samples
// alternate between output paths 0 and 1, starting on FIRST_PATH after reset.
module block_demux_1_to_2_hold_sync_high_reset
  import block_demux_1_to_2_hold_sync_high_reset_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int BLOCK_LEN  = DEFAULT_BLOCK_LEN,
  parameter int FIRST_PATH = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q0,
  output logic [DATA_WIDTH-1:0] Q1,
  output logic                  valid0,
  output logic                  valid1,
  output logic                  path,
  output logic                  blk_done
);

  localparam int              CNT_W      = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLOCK_LEN - 1);
  localparam logic             RST_PATH  = 1'(FIRST_PATH);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             path_d, path_q;
  out_flags_t       flags_d, flags_q;

  logic accept;
  logic wr0, wr1;

  assign accept = in_valid & ~hold;
  assign wr0    = accept & (path_q == PATH_0);
  assign wr1    = accept & (path_q == PATH_1);

  // Each data register loads only when its own path accepts; otherwise it is held.
  dff_hold_sync_high_reset #(
    .WIDTH (DATA_WIDTH)
  ) u_q0 (
    .clk  (clk),
    .rst  (rst),
    .hold (~wr0),
    .d    (D),
    .q    (Q0)
  );

  dff_hold_sync_high_reset #(
    .WIDTH (DATA_WIDTH)
  ) u_q1 (
    .clk  (clk),
    .rst  (rst),
    .hold (~wr1),
    .d    (D),
    .q    (Q1)
  );

  always_comb begin
    cnt_d   = cnt_q;
    path_d  = path_q;
    flags_d = flags_q;
    if (!hold) begin
      flags_d = '0;
      if (in_valid) begin
        flags_d.valid0 = (path_q == PATH_0);
        flags_d.valid1 = (path_q == PATH_1);
        if (cnt_q == CNT_LAST) begin
          cnt_d            = '0;
          path_d           = ~path_q;
          flags_d.blk_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      path_q  <= RST_PATH;
      flags_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      path_q  <= path_d;
      flags_q <= flags_d;
    end
  end

  assign valid0   = flags_q.valid0;
  assign valid1   = flags_q.valid1;
  assign blk_done = flags_q.blk_done;
  assign path     = path_q;

endmodule

// File: tb/tb_block_demux_1_to_2_hold_sync_high_reset.sv
// Self-checking bench for the block demultiplexer: directed scenarios plus random
// traffic, compared against a sample-count based reference model.
module tb_block_demux_1_to_2_hold_sync_high_reset;

  typedef struct {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       v0;
    logic       v1;
    logic       done;
    logic       path;
    int         acc;
  } model_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // DUT A: 8-bit, BLOCK_LEN=32, FIRST_PATH=0
  logic       rst_a = 1'b0, hold_a = 1'b0, iv_a = 1'b0;
  logic [7:0] d_a = '0, q0_a, q1_a;
  logic       v0_a, v1_a, path_a, done_a;
  model_t     ma;

  // DUT B: 8-bit, BLOCK_LEN=2, FIRST_PATH=1
  logic       rst_b = 1'b0, hold_b = 1'b0, iv_b = 1'b0;
  logic [7:0] d_b = '0, q0_b, q1_b;
  logic       v0_b, v1_b, path_b, done_b;
  model_t     mb;

  block_demux_1_to_2_hold_sync_high_reset #(
    .DATA_WIDTH (8), .BLOCK_LEN (32), .FIRST_PATH (0)
  ) dut_a (
    .clk (clk), .rst (rst_a), .hold (hold_a), .in_valid (iv_a), .D (d_a),
    .Q0 (q0_a), .Q1 (q1_a), .valid0 (v0_a), .valid1 (v1_a),
    .path (path_a), .blk_done (done_a)
  );

  block_demux_1_to_2_hold_sync_high_reset #(
    .DATA_WIDTH (8), .BLOCK_LEN (2), .FIRST_PATH (1)
  ) dut_b (
    .clk (clk), .rst (rst_b), .hold (hold_b), .in_valid (iv_b), .D (d_b),
    .Q0 (q0_b), .Q1 (q1_b), .valid0 (v0_b), .valid1 (v1_b),
    .path (path_b), .blk_done (done_b)
  );

  // Reference: the path of an accepted sample follows from how many blocks
  // have been completed since reset; the counter is the count modulo the block length.
  function automatic model_t model_step(input model_t m, input logic r, input logic h,
                                        input logic iv, input logic [7:0] d,
                                        input int fp, input int bl);
    model_t n = m;
    if (r) begin
      n.q0 = '0; n.q1 = '0; n.v0 = 1'b0; n.v1 = 1'b0; n.done = 1'b0;
      n.acc = 0; n.path = 1'(fp);
    end else if (!h) begin
      n.v0 = 1'b0; n.v1 = 1'b0; n.done = 1'b0;
      if (iv) begin
        if (1'(fp ^ ((m.acc / bl) % 2)) == 1'b1) begin
          n.q1 = d; n.v1 = 1'b1;
        end else begin
          n.q0 = d; n.v0 = 1'b1;
        end
        n.acc  = m.acc + 1;
        n.done = ((n.acc % bl) == 0);
        n.path = 1'(fp ^ ((n.acc / bl) % 2));
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_a(input string tag);
    check({tag, ".q0"},    32'(q0_a),   32'(ma.q0));
    check({tag, ".q1"},    32'(q1_a),   32'(ma.q1));
    check({tag, ".v0"},    32'(v0_a),   32'(ma.v0));
    check({tag, ".v1"},    32'(v1_a),   32'(ma.v1));
    check({tag, ".done"},  32'(done_a), 32'(ma.done));
    check({tag, ".path"},  32'(path_a), 32'(ma.path));
    check({tag, ".cnt"},   32'(dut_a.cnt_q), 32'(ma.acc % 32));
    check({tag, ".excl"},  32'(v0_a & v1_a), 32'(0));
  endtask

  task automatic compare_b(input string tag);
    check({tag, ".q0"},    32'(q0_b),   32'(mb.q0));
    check({tag, ".q1"},    32'(q1_b),   32'(mb.q1));
    check({tag, ".v0"},    32'(v0_b),   32'(mb.v0));
    check({tag, ".v1"},    32'(v1_b),   32'(mb.v1));
    check({tag, ".done"},  32'(done_b), 32'(mb.done));
    check({tag, ".path"},  32'(path_b), 32'(mb.path));
    check({tag, ".cnt"},   32'(dut_b.cnt_q), 32'(mb.acc % 2));
    check({tag, ".excl"},  32'(v0_b & v1_b), 32'(0));
  endtask

  task automatic step_a(input string tag, input logic r, input logic h,
                        input logic iv, input logic [7:0] d);
    rst_a = r; hold_a = h; iv_a = iv; d_a = d;
    @(posedge clk);
    #1;
    ma = model_step(ma, r, h, iv, d, 0, 32);
    compare_a(tag);
  endtask

  task automatic step_b(input string tag, input logic r, input logic h,
                        input logic iv, input logic [7:0] d);
    rst_b = r; hold_b = h; iv_b = iv; d_b = d;
    @(posedge clk);
    #1;
    mb = model_step(mb, r, h, iv, d, 1, 2);
    compare_b(tag);
  endtask

  initial begin
    int pulses;
    ma = '{q0: 8'h00, q1: 8'h00, v0: 1'b0, v1: 1'b0, done: 1'b0, path: 1'b0, acc: 0};
    mb = '{q0: 8'h00, q1: 8'h00, v0: 1'b0, v1: 1'b0, done: 1'b0, path: 1'b1, acc: 0};

    // Reset state
    step_a("a_reset", 1'b1, 1'b0, 1'b0, 8'h00);
    check("a_reset.path_first", 32'(path_a), 32'(0));

    // 64 back-to-back samples: two full blocks, one per path
    for (int i = 0; i < 64; i++) begin
      step_a("a_stream", 1'b0, 1'b0, 1'b1, 8'(i));
      if (i == 31 || i == 63) check("a_stream.blk_done_edge", 32'(done_a), 32'(1));
      if (i < 32) check("a_stream.on_q0", 32'(q0_a), 32'(i));
      else        check("a_stream.on_q1", 32'(q1_a), 32'(i));
    end
    check("a_stream.path_after_63", 32'(path_a), 32'(0));
    step_a("a_stream_idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // Gapped input 5, bubble, 6, bubble, 7
    step_a("a_gap_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step_a("a_gap", 1'b0, 1'b0, 1'b1, 8'(5 + i / 2));
      else            step_a("a_gap", 1'b0, 1'b0, 1'b0, 8'hFF);
      if (v0_a) pulses++;
      if (i == 1) check("a_gap.q0_holds_5", 32'(q0_a), 32'(5));
      if (i == 3) check("a_gap.q0_holds_6", 32'(q0_a), 32'(6));
    end
    check("a_gap.valid0_pulses", 32'(pulses), 32'(3));
    check("a_gap.cnt", 32'(dut_a.cnt_q), 32'(3));

    // Hold for 4 cycles after sample 10; 0xAA must never be captured
    step_a("a_hold_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i <= 10; i++) step_a("a_hold_pre", 1'b0, 1'b0, 1'b1, 8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      step_a("a_hold", 1'b0, 1'b1, 1'b1, 8'hAA);
      check("a_hold.no_aa_q0", 32'(q0_a == 8'hAA), 32'(0));
      check("a_hold.cnt_frozen", 32'(dut_a.cnt_q), 32'(11));
    end
    for (int i = 11; i < 32; i++) begin
      step_a("a_hold_post", 1'b0, 1'b0, 1'b1, 8'(i + 1));
      check("a_hold.no_aa_q0", 32'(q0_a == 8'hAA), 32'(0));
    end
    check("a_hold.block_end", 32'(done_a), 32'(1));
    check("a_hold.path_toggled", 32'(path_a), 32'(1));

    // Reset together with hold in the middle of a path-1 block
    step_a("a_rh_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 52; i++) step_a("a_rh_pre", 1'b0, 1'b0, 1'b1, 8'(i + 100));
    check("a_rh.on_path1", 32'(path_a), 32'(1));
    step_a("a_rh", 1'b1, 1'b1, 1'b1, 8'h55);
    check("a_rh.q1_cleared", 32'(q1_a), 32'(0));
    check("a_rh.path_first", 32'(path_a), 32'(0));
    step_a("a_rh_next", 1'b0, 1'b0, 1'b1, 8'h66);
    check("a_rh_next.q0", 32'(q0_a), 32'(8'h66));
    check("a_rh_next.cnt", 32'(dut_a.cnt_q), 32'(1));

    // Random traffic on DUT A
    for (int i = 0; i < 400; i++) begin
      step_a("a_rand", 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) != 0), 8'($urandom));
    end

    // DUT B: FIRST_PATH=1, BLOCK_LEN=2, samples A B C D
    step_b("b_reset", 1'b1, 1'b0, 1'b0, 8'h00);
    check("b_reset.path_first", 32'(path_b), 32'(1));
    step_b("b_A", 1'b0, 1'b0, 1'b1, 8'hA1);
    check("b_A.on_q1", 32'(q1_b), 32'(8'hA1));
    step_b("b_B", 1'b0, 1'b0, 1'b1, 8'hB2);
    check("b_B.on_q1_done", 32'({q1_b, done_b}), 32'({8'hB2, 1'b1}));
    step_b("b_C", 1'b0, 1'b0, 1'b1, 8'hC3);
    check("b_C.on_q0", 32'(q0_b), 32'(8'hC3));
    step_b("b_D", 1'b0, 1'b0, 1'b1, 8'hD4);
    check("b_D.on_q0_done", 32'({q0_b, done_b}), 32'({8'hD4, 1'b1}));
    for (int i = 0; i < 200; i++) begin
      step_b("b_rand", 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 2) != 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/block_demux_1_to_2_hold_sync_high_reset.md
BLOCK_DEMUX_1_TO_2_HOLD_SYNC_HIGH_RESET -- requirements
Module: block_demux_1_to_2_hold_sync_high_reset

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, sample width in bits.
REQ-002 SHALL have parameter BLOCK_LEN, default 32, samples per block; power of two, >= 2.
REQ-003 SHALL have parameter FIRST_PATH, default 0, output path selected after reset (0 or 1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port hold  input  1  freeze all internal and output state.
REQ-007 SHALL have port in_valid  input  1  D carries a sample this cycle.
REQ-008 SHALL have port D  input  DATA_WIDTH  input sample.
REQ-009 SHALL have port Q0  output  DATA_WIDTH  path-0 registered sample.
REQ-010 SHALL have port Q1  output  DATA_WIDTH  path-1 registered sample.
REQ-011 SHALL have port valid0  output  1  Q0 updated with a new sample on the last edge.
REQ-012 SHALL have port valid1  output  1  Q1 updated with a new sample on the last edge.
REQ-013 SHALL have port path  output  1  path that receives the next accepted sample.
REQ-014 SHALL have port blk_done  output  1  one-cycle pulse; last sample of a block was accepted on the last edge.

Function
REQ-015 SHALL hold an internal sample counter cnt, width log2(BLOCK_LEN), counting accepted samples within the current block.
REQ-016 SHALL accept a sample on an edge where rst=0, hold=0, in_valid=1.
REQ-017 On accept, SHALL load D into Q[path], set valid[path]=1, and clear the other valid; the other Q SHALL retain its value.
REQ-018 Latency SHALL be exactly 1 cycle: D to Q[path], with valid[path], registered.
REQ-019 On accept with cnt < BLOCK_LEN-1, SHALL increment cnt and keep path; blk_done=0.
REQ-020 On accept with cnt = BLOCK_LEN-1, SHALL wrap cnt to 0, toggle path, and set blk_done=1 for one cycle.
REQ-021 On an edge with rst=0, hold=0, in_valid=0, SHALL clear valid0, valid1, and blk_done; Q0, Q1, cnt, and path SHALL be unchanged.
REQ-022 On an edge with hold=1 and rst=0, SHALL keep Q0, Q1, valid0, valid1, blk_done, cnt, and path unchanged; in_valid/D SHALL be ignored, and that sample is dropped.
REQ-023 valid0 and valid1 SHALL never both be 1.
REQ-024 Outputs SHALL be driven only from registers; no combinational path from D to Q.

Reset
REQ-025 rst=1 SHALL take priority over hold and in_valid.
REQ-026 On reset: Q0=0, Q1=0, valid0=0, valid1=0, blk_done=0, cnt=0, path=FIRST_PATH.
REQ-027 Reset mid-block SHALL discard the partial block; the next accepted sample is sample 0 of a block on FIRST_PATH.

Structure
REQ-028 SHALL instantiate two dff_hold_sync_high_reset instances, width DATA_WIDTH, for Q0 and Q1; each hold input SHALL be asserted unless that path accepts.
REQ-029 cnt, path, valid, and blk_done registers SHALL be local to this module; no further sub-modules.
REQ-030 The FFT size constant (64) and the default BLOCK_LEN (FFT size/2) SHALL live in the shared FFT constants header, not in this module.

Verification
REQ-031 Reset, then 64 consecutive valid samples 0..63, DATA_WIDTH=8, BLOCK_LEN=32. Required: samples 0..31 on Q0 with valid0; samples 32..63 on Q1 with valid1, each 1 cycle after input; blk_done high the cycle after samples 31 and 63; path=0 after sample 63.
REQ-032 Gapped input: valid samples 5, 6, 7 with an in_valid=0 bubble between each. Required: valid0 pulses 3 times; Q0 holds 5 and then 6 through the bubbles; cnt=3.
REQ-033 hold=1 for 4 cycles after sample 10 of a block, with in_valid=1 and D=0xAA during the hold. Required: Q, valid, cnt, and path frozen; 0xAA never appears on an output; the block still ends after 32 accepted samples.
REQ-034 rst and hold both asserted during sample 20 of a block on path 1. Required: all outputs reset per REQ-026; the next sample goes to Q0 with cnt starting at 0.
REQ-035 FIRST_PATH=1, BLOCK_LEN=2, samples A, B, C, D. Required: A and B on Q1; C and D on Q0; blk_done after B and after D; valid0 and valid1 never high together.
